// File: rtl/logic_flip_unit.sv
// Registered eight-op bitwise logic unit with valid/ready handshake and a chaining accumulator.
// Optional even-parity output register is enabled by defining LOGICFLIP_PARITY_EN.
module logic_flip_unit #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             acc,
  input  logic             clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             zero,
  output logic [CNT_W-1:0] xfer_cnt
`ifdef LOGICFLIP_PARITY_EN
  ,
  output logic             par
`endif
);

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_XOR  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XNOR = 3'd5;
  localparam logic [2:0] OP_ANDN = 3'd6;

  function automatic logic [WIDTH-1:0] logic_op(input logic [2:0]       sel,
                                                input logic [WIDTH-1:0] x,
                                                input logic [WIDTH-1:0] y);
    logic [WIDTH-1:0] r;
    case (sel)
      OP_AND:  r = x & y;
      OP_OR:   r = x | y;
      OP_XOR:  r = x ^ y;
      OP_NAND: r = ~(x & y);
      OP_NOR:  r = ~(x | y);
      OP_XNOR: r = ~(x ^ y);
      OP_ANDN: r = x & ~y;
      default: r = x;
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] bsel_p0;
  logic [WIDTH-1:0] f_p0;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready = !out_valid || out_ready;
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  // A same-cycle clear makes the accumulator look all-ones to this operation.
  assign bsel_p0 = acc ? (clr ? {WIDTH{1'b1}} : acc_q) : b;
  assign f_p0    = logic_op(op, a, bsel_p0);

  // Output stage: result, flags, accumulator and counter update on input transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c         <= '0;
      zero      <= 1'b0;
      out_valid <= 1'b0;
      acc_q     <= {WIDTH{1'b1}};
      xfer_cnt  <= '0;
    end else if (in_xfer) begin
      c         <= f_p0;
      zero      <= (f_p0 == '0);
      out_valid <= 1'b1;
      acc_q     <= f_p0;
      xfer_cnt  <= xfer_cnt + 1'b1;
    end else begin
      if (out_xfer)
        out_valid <= 1'b0;
      // A stalled output freezes the accumulator along with everything else.
      if (clr && in_ready)
        acc_q <= {WIDTH{1'b1}};
    end
  end

`ifdef LOGICFLIP_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      par <= 1'b0;
    else if (in_xfer)
      par <= ^f_p0;
  end
`endif

endmodule

// File: tb/tb_logic_flip_unit.sv
// Scoreboard bench for logic_flip_unit; a second instance with CNT_W=4 shares inputs to check counter wrap.
// Define LOGICFLIP_PARITY_EN to also exercise the parity output.
module tb_logic_flip_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0, b = '0;
  logic [2:0] op = '0;
  logic       acc = 1'b0, clr = 1'b0, out_ready = 1'b1;
  logic       in_ready, out_valid, zero;
  logic [7:0] c;
  logic [15:0] xfer_cnt;
  logic       in_ready2, out_valid2, zero2;
  logic [7:0] c2;
  logic [3:0] xfer_cnt2;
`ifdef LOGICFLIP_PARITY_EN
  logic       par, par2;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0]  q[$];
  logic [7:0]  m_acc = 8'hFF;
  int          m_cnt = 0;

  always #5 clk = ~clk;

  logic_flip_unit #(.WIDTH(8), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b), .op(op),
    .acc(acc), .clr(clr), .out_valid(out_valid), .out_ready(out_ready), .c(c), .zero(zero),
    .xfer_cnt(xfer_cnt)
`ifdef LOGICFLIP_PARITY_EN
    , .par(par)
`endif
  );

  logic_flip_unit #(.WIDTH(8), .CNT_W(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready2), .a(a), .b(b), .op(op),
    .acc(acc), .clr(clr), .out_valid(out_valid2), .out_ready(out_ready), .c(c2), .zero(zero2),
    .xfer_cnt(xfer_cnt2)
`ifdef LOGICFLIP_PARITY_EN
    , .par(par2)
`endif
  );

  function automatic logic [7:0] model(input logic [2:0] s, input logic [7:0] x, input logic [7:0] y);
    case (s)
      3'd0: return x & y;
      3'd1: return x | y;
      3'd2: return x ^ y;
      3'd3: return ~(x & y);
      3'd4: return ~(x | y);
      3'd5: return ~(x ^ y);
      3'd6: return x & ~y;
      default: return x;
    endcase
  endfunction

  task automatic model_reset();
    q.delete();
    m_acc = 8'hFF;
    m_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; acc = 1'b0; clr = 1'b0; out_ready = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive one operand pair, wait (bounded) for acceptance, push the expected result.
  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic [2:0] top,
                      input logic tacc, input logic tclr);
    logic [7:0] bs;
    logic [7:0] f;
    int n;
    @(negedge clk);
    in_valid = 1'b1; a = ta; b = tb; op = top; acc = tacc; clr = tclr;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready=%0b required=1", in_ready);
    end
    bs = tacc ? (tclr ? 8'hFF : m_acc) : tb;
    f = model(top, ta, bs);
    m_acc = f;
    m_cnt++;
    q.push_back(f);
    @(posedge clk);
    #1;
    in_valid = 1'b0; acc = 1'b0; clr = 1'b0;
  endtask

  task automatic check_result(input string name);
    logic [7:0] e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, c=%02h", name, c);
      return;
    end
    e = q.pop_front();
    if (c !== e || zero !== (e == 8'h00) || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s: c=%02h zero=%0b vld=%0b required c=%02h zero=%0b vld=1",
               name, c, zero, out_valid, e, (e == 8'h00));
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk); out_ready = 1'b0;
    send(8'h5A, 8'hFF, 3'd7, 1'b0, 1'b0);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    checks++;
    if (c !== 8'h00 || out_valid !== 1'b0 || xfer_cnt !== 16'd0 || zero !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: c=%02h vld=%0b cnt=%0d zero=%0b rdy=%0b required 00/0/0/0/1",
               c, out_valid, xfer_cnt, zero, in_ready);
    end
`ifdef LOGICFLIP_PARITY_EN
    checks++;
    if (par !== 1'b0) begin errors++; $display("FAIL reset_par: par=%0b required=0", par); end
`endif
    @(negedge clk);
    rst = 1'b0; out_ready = 1'b1;
    model_reset();
    // accumulator after reset must read as all-ones
    send(8'hA5, 8'h00, 3'd0, 1'b1, 1'b0);
    check_result("reset_acc_ones");
  endtask

  task automatic test_op_sweep();
    logic [7:0] tbl [8];
    tbl = '{8'h42, 8'hDB, 8'h99, 8'hBD, 8'h24, 8'h66, 8'h81, 8'hC3};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      send(8'hC3, 8'h5A, 3'(i), 1'b0, 1'b0);
      checks++;
      if (c !== tbl[i]) begin
        errors++;
        $display("FAIL sweep_table op%0d: c=%02h required=%02h", i, c, tbl[i]);
      end
      check_result("sweep_model");
    end
    checks++;
    if (xfer_cnt !== 16'd8) begin
      errors++; $display("FAIL sweep_cnt: cnt=%0d required=8", xfer_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] held;
    int cnt_before;
    send(8'h3C, 8'h0F, 3'd1, 1'b0, 1'b0);
    held = q[0];
    check_result("bp_first");
    cnt_before = m_cnt;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      out_ready = 1'b0; in_valid = 1'b1; a = 8'h11; b = 8'h22; op = 3'd2;
      #1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: rdy=%0b required=0", in_ready); end
      @(posedge clk); #1;
      checks++;
      if (c !== held || xfer_cnt !== 16'(cnt_before) || out_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold: c=%02h cnt=%0d vld=%0b required c=%02h cnt=%0d vld=1",
                 c, xfer_cnt, out_valid, held, cnt_before);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: rdy=%0b required=1", in_ready); end
    m_acc = model(3'd2, 8'h11, 8'h22);
    m_cnt++;
    q.push_back(m_acc);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check_result("bp_release");
    checks++;
    if (xfer_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL bp_cnt: cnt=%0d required=%0d", xfer_cnt, m_cnt);
    end
  endtask

  task automatic test_accumulate();
    send(8'hF0, 8'h55, 3'd0, 1'b1, 1'b1);
    checks++;
    if (c !== 8'hF0) begin errors++; $display("FAIL acc_clr: c=%02h required=f0", c); end
    check_result("acc_clr_model");
    send(8'h3C, 8'hFF, 3'd0, 1'b1, 1'b0);
    checks++;
    if (c !== 8'h30) begin errors++; $display("FAIL acc_chain: c=%02h required=30", c); end
    check_result("acc_chain_model");
    send(8'h0F, 8'hFF, 3'd0, 1'b1, 1'b0);
    checks++;
    if (c !== 8'h00 || zero !== 1'b1) begin
      errors++; $display("FAIL acc_zero: c=%02h zero=%0b required 00/1", c, zero);
    end
    check_result("acc_zero_model");
    // standalone clear, then chain from all-ones
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    m_acc = 8'hFF;
    send(8'h96, 8'h00, 3'd2, 1'b1, 1'b0);
    check_result("acc_standalone_clr");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 20; i++) begin
      send(8'($urandom), 8'($urandom), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0));
      check_result("b2b_random");
    end
    checks++;
    if (xfer_cnt !== 16'(m_cnt)) begin
      errors++; $display("FAIL b2b_cnt: cnt=%0d required=%0d", xfer_cnt, m_cnt);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'(i * 13), 8'hA5, 3'(i % 8), 1'b0, 1'b0);
      check_result("wrap_data");
    end
    checks++;
    if (xfer_cnt2 !== 4'd1 || xfer_cnt !== 16'd17) begin
      errors++;
      $display("FAIL wrap_cnt: cnt4=%0d cnt16=%0d required 1/17", xfer_cnt2, xfer_cnt);
    end
  endtask

`ifdef LOGICFLIP_PARITY_EN
  task automatic test_parity();
    send(8'h07, 8'h00, 3'd7, 1'b0, 1'b0);
    checks++;
    if (par !== 1'b1) begin errors++; $display("FAIL par_07: par=%0b required=1", par); end
    check_result("par_07_data");
    send(8'h03, 8'h00, 3'd7, 1'b0, 1'b0);
    checks++;
    if (par !== 1'b0) begin errors++; $display("FAIL par_03: par=%0b required=0", par); end
    check_result("par_03_data");
  endtask
`endif

  initial begin
    test_reset();
    test_op_sweep();
    test_backpressure();
    test_accumulate();
    test_back_to_back();
`ifdef LOGICFLIP_PARITY_EN
    test_parity();
`endif
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/logic_flip_unit.md
# logic_flip_unit

Parametrised, registered bitwise logic unit: the next generation of the team's two-input combinational gate block. It applies one of eight selectable bitwise operations across a WIDTH-bit operand pair, registers the result behind a valid/ready handshake, and can chain results through an internal accumulator. It sits between operand producers and any downstream consumer that needs flow-controlled, one-cycle-latency logic results.

## Interface
Parameters:
- WIDTH, 8, operand/result width in bits (≥1)
- CNT_W, 16, width of the transfer counter

Ports (clock and reset first):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  unit can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B (ignored when acc=1)
- op  in  3  operation select, sampled with the transfer
- acc  in  1  use accumulator register in place of b
- clr  in  1  synchronous accumulator clear to all-ones
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- c  out  WIDTH  registered result
- zero  out  1  registered flag, c == 0
- xfer_cnt  out  CNT_W  count of accepted input transfers
- par  out  1  registered even parity of c (only with LOGICFLIP_PARITY_EN)

## Operation
- Input transfer: in_valid && in_ready. Output transfer: out_valid && out_ready.
- in_ready = !out_valid || out_ready (combinational; single output stage).
- Operand selection: bsel = acc ? acc_q : b; if clr is high the same cycle, acc_q is taken as all-ones for bsel.
- op encoding: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 ANDN (a & ~bsel), 7 PASS (a).
- On input transfer: c <= f(op, a, bsel); zero <= (f == 0); out_valid <= 1; acc_q <= f; xfer_cnt <= xfer_cnt + 1 (wraps to 0 after all-ones).
- On output transfer with no input transfer: out_valid <= 0; c and zero hold their values.
- clr without input transfer: acc_q <= all-ones. clr with input transfer: result overwrites acc_q (bsel already used all-ones).
- Backpressure: out_valid && !out_ready → c, zero, par, acc_q, xfer_cnt all hold; in_ready = 0.
- Reset mid-operation discards any pending result; no partial state survives.

## Timing
- Reset values: c = 0, zero = 0, out_valid = 0, par = 0, acc_q = all-ones, xfer_cnt = 0; in_ready = 1 once rst deasserts.
- Latency: result visible one clk edge after the input transfer.
- Throughput: one result per cycle while out_ready is held high.
- Simultaneous input and output transfer: new result replaces old in the same edge; out_valid stays 1.
- All outputs except in_ready are registered.

## Configuration
- LOGICFLIP_PARITY_EN defined: par port present, par <= ^f on every input transfer, held otherwise, reset 0.
- Not defined: par port and its register absent; all other behaviour identical.

## Test plan
- Reset: assert rst asynchronously mid-cycle → c=0x00, out_valid=0, xfer_cnt=0, acc_q=0xFF, in_ready=1 (WIDTH=8).
- Op sweep: a=0xC3, b=0x5A, op 0..7 back-to-back with out_ready=1 → c = 0x42, 0xDB, 0x99, 0xBD, 0x24, 0x66, 0x81, 0xC3 on consecutive cycles; xfer_cnt=8.
- Backpressure: one transfer then out_ready=0 for 3 cycles with in_valid=1 → in_ready=0, c held, xfer_cnt unchanged; out_ready=1 → next operand accepted the same cycle.
- Accumulate: clr=1 with a=0xF0, op=AND, acc=1 → c=0xF0; then a=0x3C, acc=1, AND → c=0x30; then a=0x0F, AND → c=0x00, zero=1.
- Wrap: CNT_W=4, 17 transfers → xfer_cnt = 1.
- Parity (macro defined): a=0x07, op=PASS → par=1; a=0x03 → par=0.
